// File: rtl/binary_blob_tracker_if.sv
// Pixel-stream in / frame-result out bundle for binary_blob_tracker.
// master drives pixels and reads results; slave is the tracker.
interface binary_blob_tracker_if;
    logic        iFVAL;
    logic        iDVAL;
    logic [11:0] iGREY;
    logic        oVALID;
    logic        oFOUND;
    logic [19:0] oCOUNT;
    logic [11:0] oX_MIN;
    logic [11:0] oX_MAX;
    logic [11:0] oY_MIN;
    logic [11:0] oY_MAX;
    logic [11:0] oCX;
    logic [11:0] oCY;

    modport master (
        output iFVAL, iDVAL, iGREY,
        input  oVALID, oFOUND, oCOUNT,
        input  oX_MIN, oX_MAX, oY_MIN, oY_MAX, oCX, oCY
    );

    modport slave (
        input  iFVAL, iDVAL, iGREY,
        output oVALID, oFOUND, oCOUNT,
        output oX_MIN, oX_MAX, oY_MIN, oY_MAX, oCX, oCY
    );
endinterface

// File: rtl/binary_blob_tracker.sv
// Per-frame foreground count, bounding box and centre of a grey/binary stream.
// BLOB_CENTROID_EN: mean-position centre via serial dividers instead of box centre.
module binary_blob_tracker #(
    parameter logic [11:0] THRESH = 12'd2048,
    parameter logic [11:0] MAX_X  = 12'd4095
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    binary_blob_tracker_if.slave   bus
);

`ifdef BLOB_CENTROID_EN
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CALC, S_PUBLISH} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_PUBLISH} state_t;
`endif

    state_t      state_q, state_d;
    logic        fval_q, fval_d, dval_q, dval_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic [19:0] cnt_q, cnt_d;
    logic [11:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [11:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic        valid_q, valid_d, found_q, found_d;
    logic [19:0] ocnt_q, ocnt_d;
    logic [11:0] oxmin_q, oxmin_d, oxmax_q, oxmax_d;
    logic [11:0] oymin_q, oymin_d, oymax_q, oymax_d;
    logic [11:0] ocx_q, ocx_d, ocy_q, ocy_d;
    logic        dv, fval_rise, fval_fall, dval_fall, fg;

`ifdef BLOB_CENTROID_EN
    logic [31:0] sumx_q, sumx_d, sumy_q, sumy_d;
    logic [31:0] qx_q, qx_d, qy_q, qy_d;
    logic [19:0] rx_q, rx_d, ry_q, ry_d;
    logic [4:0]  it_q, it_d;

    // One restoring step: remainder stays below the divisor, so 20 bits hold it.
    function automatic logic [51:0] div_step(input logic [19:0] r,
                                             input logic [31:0] q,
                                             input logic [19:0] d);
        logic [20:0] rs;
        logic [19:0] rn;
        logic        qb;
        rs = {r, q[31]};
        if (rs >= {1'b0, d}) begin
            rn = 20'(rs - {1'b0, d});
            qb = 1'b1;
        end else begin
            rn = rs[19:0];
            qb = 1'b0;
        end
        return {rn, q[30:0], qb};
    endfunction
`else
    logic [12:0] sx, sy;
`endif

    always_comb begin
        dv        = bus.iFVAL & bus.iDVAL;
        fval_rise = bus.iFVAL & ~fval_q;
        fval_fall = ~bus.iFVAL & fval_q;
        dval_fall = ~dv & dval_q;
        fg        = dv & (bus.iGREY < THRESH);
        fval_d    = bus.iFVAL;
        dval_d    = dv;

        x_d = x_q;
        y_d = y_q;
        if (fval_rise) begin
            x_d = '0;
            y_d = '0;
        end else if (dv) begin
            x_d = (x_q == MAX_X) ? x_q : x_q + 12'd1;
        end else if (dval_fall) begin
            x_d = '0;
            y_d = (y_q == 12'hFFF) ? y_q : y_q + 12'd1;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        valid_d = 1'b0;
        found_d = found_q;
        ocnt_d  = ocnt_q;
        oxmin_d = oxmin_q;
        oxmax_d = oxmax_q;
        oymin_d = oymin_q;
        oymax_d = oymax_q;
        ocx_d   = ocx_q;
        ocy_d   = ocy_q;
`ifdef BLOB_CENTROID_EN
        sumx_d = sumx_q;
        sumy_d = sumy_q;
        qx_d   = qx_q;
        qy_d   = qy_q;
        rx_d   = rx_q;
        ry_d   = ry_q;
        it_d   = it_q;
`else
        sx = {1'b0, xmin_q} + {1'b0, xmax_q};
        sy = {1'b0, ymin_q} + {1'b0, ymax_q};
`endif

        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                xmin_d = 12'hFFF;
                xmax_d = '0;
                ymin_d = 12'hFFF;
                ymax_d = '0;
`ifdef BLOB_CENTROID_EN
                sumx_d = '0;
                sumy_d = '0;
`endif
                // The strobe cycle is spent clearing; a rise here is lost.
                if (fval_rise && !valid_q) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (fg) begin
                    cnt_d  = (cnt_q == 20'hFFFFF) ? cnt_q : cnt_q + 20'd1;
                    xmin_d = (x_q < xmin_q) ? x_q : xmin_q;
                    xmax_d = (x_q > xmax_q) ? x_q : xmax_q;
                    ymin_d = (y_q < ymin_q) ? y_q : ymin_q;
                    ymax_d = (y_q > ymax_q) ? y_q : ymax_q;
`ifdef BLOB_CENTROID_EN
                    sumx_d = sumx_q + 32'(x_q);
                    sumy_d = sumy_q + 32'(y_q);
`endif
                end
                if (fval_fall) begin
`ifdef BLOB_CENTROID_EN
                    qx_d    = sumx_q;
                    qy_d    = sumy_q;
                    rx_d    = '0;
                    ry_d    = '0;
                    it_d    = '0;
                    state_d = S_CALC;
`else
                    state_d = S_PUBLISH;
`endif
                end
            end
`ifdef BLOB_CENTROID_EN
            S_CALC: begin
                {rx_d, qx_d} = div_step(rx_q, qx_q, cnt_q);
                {ry_d, qy_d} = div_step(ry_q, qy_q, cnt_q);
                it_d = it_q + 5'd1;
                if (it_q == 5'd31) state_d = S_PUBLISH;
            end
`endif
            S_PUBLISH: begin
                valid_d = 1'b1;
                found_d = (cnt_q != 20'd0);
                ocnt_d  = cnt_q;
                if (cnt_q == 20'd0) begin
                    oxmin_d = '0;
                    oxmax_d = '0;
                    oymin_d = '0;
                    oymax_d = '0;
                    ocx_d   = '0;
                    ocy_d   = '0;
                end else begin
                    oxmin_d = xmin_q;
                    oxmax_d = xmax_q;
                    oymin_d = ymin_q;
                    oymax_d = ymax_q;
`ifdef BLOB_CENTROID_EN
                    ocx_d = (|qx_q[31:12]) ? 12'hFFF : qx_q[11:0];
                    ocy_d = (|qy_q[31:12]) ? 12'hFFF : qy_q[11:0];
`else
                    ocx_d = 12'(sx >> 1);
                    ocy_d = 12'(sy >> 1);
`endif
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            fval_q  <= 1'b1;
            dval_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            valid_q <= 1'b0;
            found_q <= 1'b0;
            ocnt_q  <= '0;
            oxmin_q <= '0;
            oxmax_q <= '0;
            oymin_q <= '0;
            oymax_q <= '0;
            ocx_q   <= '0;
            ocy_q   <= '0;
`ifdef BLOB_CENTROID_EN
            sumx_q  <= '0;
            sumy_q  <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            it_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            fval_q  <= fval_d;
            dval_q  <= dval_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            valid_q <= valid_d;
            found_q <= found_d;
            ocnt_q  <= ocnt_d;
            oxmin_q <= oxmin_d;
            oxmax_q <= oxmax_d;
            oymin_q <= oymin_d;
            oymax_q <= oymax_d;
            ocx_q   <= ocx_d;
            ocy_q   <= ocy_d;
`ifdef BLOB_CENTROID_EN
            sumx_q  <= sumx_d;
            sumy_q  <= sumy_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            it_q    <= it_d;
`endif
        end
    end

    assign bus.oVALID = valid_q;
    assign bus.oFOUND = found_q;
    assign bus.oCOUNT = ocnt_q;
    assign bus.oX_MIN = oxmin_q;
    assign bus.oX_MAX = oxmax_q;
    assign bus.oY_MIN = oymin_q;
    assign bus.oY_MAX = oymax_q;
    assign bus.oCX    = ocx_q;
    assign bus.oCY    = ocy_q;

endmodule

// File: tb/tb_binary_blob_tracker.sv
// Scoreboard bench for binary_blob_tracker: frames built as images, expected
// results computed from the image and pushed; a monitor pops on oVALID.
module tb_binary_blob_tracker;

`ifdef BLOB_CENTROID_EN
    localparam int LAT     = 34;
    localparam int MIN_GAP = 35;
`else
    localparam int LAT     = 2;
    localparam int MIN_GAP = 3;
`endif

    typedef struct {
        logic        found;
        logic [19:0] cnt;
        logic [11:0] xmin, xmax, ymin, ymax, cx, cy;
        int          at_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_fall = -100000;
    exp_t exp_q[$];
    exp_t mon_e, last_e;
    bit   have_last = 1'b0;
    bit   prev_v = 1'b0;
    logic [11:0] img [16][16];

    binary_blob_tracker_if bus();

    binary_blob_tracker dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    function automatic logic [127:0] outs();
        return 128'({bus.oVALID, bus.oFOUND, bus.oCOUNT, bus.oX_MIN,
                     bus.oX_MAX, bus.oY_MIN, bus.oY_MAX, bus.oCX, bus.oCY});
    endfunction

    function automatic logic [127:0] pack(input exp_t e);
        return 128'({1'b0, e.found, e.cnt, e.xmin, e.xmax,
                     e.ymin, e.ymax, e.cx, e.cy});
    endfunction

    // Reference: scan the image, apply the threshold, reduce with plain arithmetic.
    function automatic exp_t model(input int w, input int h);
        exp_t e;
        int n = 0, x0 = 4095, x1 = 0, y0 = 4095, y1 = 0;
        longint sx = 0, sy = 0;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                if (img[y][x] < 12'd2048) begin
                    n++;
                    sx += x;
                    sy += y;
                    if (x < x0) x0 = x;
                    if (x > x1) x1 = x;
                    if (y < y0) y0 = y;
                    if (y > y1) y1 = y;
                end
        e.at_edge = 0;
        e.found = (n != 0);
        e.cnt = 20'(n);
        if (n == 0) begin
            e.xmin = '0; e.xmax = '0; e.ymin = '0; e.ymax = '0;
            e.cx = '0; e.cy = '0;
        end else begin
            e.xmin = 12'(x0); e.xmax = 12'(x1);
            e.ymin = 12'(y0); e.ymax = 12'(y1);
`ifdef BLOB_CENTROID_EN
            e.cx = 12'(sx / n);
            e.cy = 12'(sy / n);
`else
            e.cx = 12'((x0 + x1) / 2);
            e.cy = 12'((y0 + y1) / 2);
`endif
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (bus.oVALID) begin
            chk("valid_single_cycle", 128'(prev_v), 128'(0));
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 128'(1), 128'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("latency", 128'(cyc), 128'(mon_e.at_edge));
                chk("found", 128'(bus.oFOUND), 128'(mon_e.found));
                chk("count", 128'(bus.oCOUNT), 128'(mon_e.cnt));
                chk("x_min", 128'(bus.oX_MIN), 128'(mon_e.xmin));
                chk("x_max", 128'(bus.oX_MAX), 128'(mon_e.xmax));
                chk("y_min", 128'(bus.oY_MIN), 128'(mon_e.ymin));
                chk("y_max", 128'(bus.oY_MAX), 128'(mon_e.ymax));
                chk("cx", 128'(bus.oCX), 128'(mon_e.cx));
                chk("cy", 128'(bus.oCY), 128'(mon_e.cy));
                last_e = mon_e;
                have_last = 1'b1;
            end
        end
        prev_v = bus.oVALID;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_bg();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                img[y][x] = 12'd4095;
    endtask

    task automatic fill_rand();
        int p;
        p = $urandom_range(0, 4);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                if (int'($urandom_range(0, 7)) < p)
                    img[y][x] = 12'($urandom_range(0, 2047));
                else
                    img[y][x] = 12'($urandom_range(2048, 4095));
    endtask

    task automatic line(input int w, input int y);
        int hb;
        for (int x = 0; x < w; x++) begin
            bus.iDVAL = 1'b1;
            bus.iGREY = img[y][x];
            step();
        end
        hb = $urandom_range(1, 3);
        repeat (hb) begin
            bus.iDVAL = 1'b0;
            bus.iGREY = 12'($urandom);
            step();
        end
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            step();
            bus.iDVAL = 1'($urandom);
            bus.iGREY = 12'($urandom);
        end
    endtask

    task automatic send_frame(input int w, input int h);
        int   rise;
        bit   acc;
        exp_t e;
        bus.iFVAL = 1'b1;
        bus.iDVAL = 1'b0;
        rise = cyc + 1;
        acc = (rise - last_fall) >= MIN_GAP;
        step();
        step();
        for (int y = 0; y < h; y++) line(w, y);
        bus.iFVAL = 1'b0;
        bus.iDVAL = 1'($urandom);
        if (acc) begin
            e = model(w, h);
            e.at_edge = cyc + LAT;
            exp_q.push_back(e);
            last_fall = cyc + 1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.iFVAL = 1'b0;
        bus.iDVAL = 1'b0;
        bus.iGREY = '0;
        repeat (3) step();
        chk("reset_state", outs(), 128'(0));
        rst_n = 1'b1;
        gap(4);

        fill_bg();
        img[2][5] = 12'd0;
        send_frame(8, 4);
        gap(MIN_GAP + 5);

        // Frame cut by reset, released with iFVAL high: must never publish.
        fill_bg();
        img[1][2] = 12'd0;
        bus.iFVAL = 1'b1;
        bus.iDVAL = 1'b0;
        step();
        step();
        line(8, 0);
        line(8, 1);
        rst_n = 1'b0;
        step();
        step();
        chk("reset_mid_frame", outs(), 128'(0));
        rst_n = 1'b1;
        line(8, 2);
        line(8, 3);
        bus.iFVAL = 1'b0;
        last_fall = -100000;
        gap(MIN_GAP + 5);

        fill_bg();
        for (int y = 1; y <= 4; y++)
            for (int x = 3; x <= 6; x++)
                img[y][x] = 12'd100;
        send_frame(16, 8);
        gap(MIN_GAP + 5);

        fill_bg();
        send_frame(8, 4);
        gap(MIN_GAP + 5);

        fill_bg();
        img[0][0] = 12'd0;
        img[0][9] = 12'd0;
        send_frame(12, 3);
        gap(MIN_GAP + 5);

        fill_rand();
        send_frame(6, 3);
        gap(1);
        send_frame(6, 3);
        gap(MIN_GAP);
        fill_rand();
        send_frame(7, 5);
        gap(MIN_GAP - 1);
        send_frame(7, 5);
        gap(MIN_GAP);
        fill_rand();
        send_frame(9, 4);
        gap(MIN_GAP);
        fill_rand();
        send_frame(5, 6);
        gap(MIN_GAP + 2);

        for (int i = 0; i < 40; i++) begin
            fill_rand();
            send_frame($urandom_range(1, 16), $urandom_range(1, 16));
            gap($urandom_range(1, MIN_GAP + 4));
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        repeat (3) step();
        if (have_last) chk("result_hold", outs(), pack(last_e));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
